// File: rtl/mic_meter_pkg.sv
// rtl/mic_meter_pkg.sv - shared widths, midscale code and FSM state type for the mic level meter
package mic_meter_pkg;

  localparam int MIC_W        = 12;
  localparam int MAG_W        = 11;
  localparam int LEVEL_W      = 4;
  localparam int MIC_MIDSCALE = 2048;

  typedef enum logic {
    ACCUM  = 1'b0,
    UPDATE = 1'b1
  } meter_state_t;

endpackage

// File: rtl/peak_hold_decay.sv
// rtl/peak_hold_decay.sv - peak level held for HOLD_WINDOWS windows, then decays one step per window
module peak_hold_decay
  import mic_meter_pkg::*;
#(
  parameter int HOLD_WINDOWS = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               update,
  input  logic [LEVEL_W-1:0] level_in,
  output logic [LEVEL_W-1:0] level_out
);

  localparam logic [7:0] HOLD = 8'(HOLD_WINDOWS);

  logic [LEVEL_W-1:0] r_level;
  logic [7:0]         r_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= '0;
      r_hold  <= '0;
    end else if (update) begin
      if (level_in >= r_level) begin
        r_level <= level_in;
        r_hold  <= HOLD;
      end else if (r_hold != 8'd0) begin
        r_hold <= r_hold - 8'd1;
      end else if (r_level != '0) begin
        r_level <= r_level - 1'b1;
      end
    end
  end

  assign level_out = r_level;

endmodule

// File: rtl/mic_level_meter.sv
// rtl/mic_level_meter.sv - windowed peak-amplitude meter for a 12-bit mic ADC stream
module mic_level_meter
  import mic_meter_pkg::*;
#(
  parameter int WINDOW_SAMPLES = 1000,
  parameter int HOLD_WINDOWS   = 10,
  parameter int MIDSCALE       = MIC_MIDSCALE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sample_valid,
  input  logic [MIC_W-1:0]   sample,
  output logic [LEVEL_W-1:0] level_raw,
  output logic [LEVEL_W-1:0] level_peak,
  output logic [MIC_W-1:0]   peak_sample,
  output logic               level_valid
);

  localparam logic [MIC_W:0] MID = (MIC_W+1)'(MIDSCALE);
  localparam logic [16:0]    WIN = 17'(WINDOW_SAMPLES);

  meter_state_t r_state, w_state_next;
  logic [15:0]        r_cnt;
  logic [MAG_W-1:0]   r_max_mag;
  logic [MIC_W-1:0]   r_max_code;
  logic [LEVEL_W-1:0] r_level_raw;
  logic [MIC_W-1:0]   r_peak_sample;
  logic               r_level_valid;

  logic [MIC_W:0]   w_diff;
  logic [MAG_W-1:0] w_mag;
  logic [15:0]      w_cnt_base;
  logic [16:0]      w_cnt_next;
  logic [MAG_W-1:0] w_max_base;
  logic             w_take;
  logic             w_win_done;
  logic             w_in_update;

  always_comb begin
    w_diff = ({1'b0, sample} >= MID) ? ({1'b0, sample} - MID) : (MID - {1'b0, sample});
    w_mag  = (|w_diff[MIC_W:MAG_W]) ? '1 : w_diff[MAG_W-1:0];
  end

  // In UPDATE the window state is being cleared, so a sample arriving now starts from zero.
  always_comb begin
    w_cnt_base = w_in_update ? 16'd0 : r_cnt;
    w_max_base = w_in_update ? '0 : r_max_mag;
    w_cnt_next = {1'b0, w_cnt_base} + 17'd1;
    w_take     = sample_valid && ((w_cnt_base == 16'd0) || (w_mag > w_max_base));
    w_win_done = sample_valid && (w_cnt_next == WIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ACCUM;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ACCUM:   w_state_next = w_win_done ? UPDATE : ACCUM;
      UPDATE:  w_state_next = w_win_done ? UPDATE : ACCUM;
      default: w_state_next = ACCUM;
    endcase
  end

  always_comb begin
    w_in_update = (r_state == UPDATE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_max_mag  <= '0;
      r_max_code <= '0;
    end else begin
      if (sample_valid)     r_cnt <= w_cnt_next[15:0];
      else if (w_in_update) r_cnt <= '0;
      if (w_take) begin
        r_max_mag  <= w_mag;
        r_max_code <= sample;
      end else if (w_in_update) begin
        r_max_mag  <= '0;
        r_max_code <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level_raw   <= '0;
      r_peak_sample <= '0;
      r_level_valid <= 1'b0;
    end else begin
      r_level_valid <= w_in_update;
      if (w_in_update) begin
        r_level_raw   <= r_max_mag[MAG_W-1 -: LEVEL_W];
        r_peak_sample <= r_max_code;
      end
    end
  end

  peak_hold_decay #(
    .HOLD_WINDOWS(HOLD_WINDOWS)
  ) u_peak_hold_decay (
    .clk      (clk),
    .rst_n    (rst_n),
    .update   (w_in_update),
    .level_in (r_max_mag[MAG_W-1 -: LEVEL_W]),
    .level_out(level_peak)
  );

  assign level_raw   = r_level_raw;
  assign peak_sample = r_peak_sample;
  assign level_valid = r_level_valid;

endmodule
